// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester arbiter for a single-port SRAM macro
// Round-robin or starvation-bounded m1 priority; 1-cycle read return steering.
module sram_port_arbiter #(
   parameter int BUS_WIDTH  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int PRIO_MODE  = 0,
   parameter int MAX_STREAK = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [BUS_WIDTH-1:0]    m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   output logic                    m0_gnt,
   output logic                    m0_rvalid,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [BUS_WIDTH-1:0]    m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   output logic                    m1_gnt,
   output logic                    m1_rvalid,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic [BUS_WIDTH-1:0]    ram_raddr,
   output logic                    ram_ren,
   output logic [BUS_WIDTH-1:0]    ram_waddr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   output logic [DATA_WIDTH/8-1:0] ram_wen,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);

   localparam logic [3:0] MAX_S = 4'(MAX_STREAK);

   logic       last_gnt_q, last_gnt_d;   // 1 = m1 was granted last
   logic [3:0] streak_q, streak_d;
   logic       rd_valid_q, rd_valid_d;
   logic       rd_owner_q, rd_owner_d;   // 1 = read belongs to m1

   logic                    any_req;
   logic                    contend;
   logic                    sel_m1;
   logic                    win_we;
   logic [BUS_WIDTH-1:0]    win_addr;
   logic [DATA_WIDTH-1:0]   win_wdata;
   logic [DATA_WIDTH/8-1:0] win_wstrb;

   always_comb begin
      any_req    = 1'b0;
      contend    = 1'b0;
      sel_m1     = 1'b0;
      m0_gnt     = 1'b0;
      m1_gnt     = 1'b0;
      ram_ren    = 1'b0;
      ram_raddr  = '0;
      ram_wen    = '0;
      ram_waddr  = '0;
      ram_wdata  = '0;
      last_gnt_d = last_gnt_q;
      streak_d   = streak_q;
      rd_valid_d = 1'b0;
      rd_owner_d = rd_owner_q;

      // Grants are held low while reset is asserted so the SRAM sees no strobes.
      any_req = resetn & (m0_req | m1_req);
      contend = resetn & m0_req & m1_req;

      if (contend) begin
         if (PRIO_MODE == 0) sel_m1 = ~last_gnt_q;
         else                sel_m1 = (streak_q != MAX_S);
      end else begin
         sel_m1 = m1_req;
      end

      m0_gnt = any_req & ~sel_m1;
      m1_gnt = any_req & sel_m1;

      win_we    = sel_m1 ? m1_we    : m0_we;
      win_addr  = sel_m1 ? m1_addr  : m0_addr;
      win_wdata = sel_m1 ? m1_wdata : m0_wdata;
      win_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;

      if (any_req) begin
         if (win_we) begin
            ram_wen   = win_wstrb;
            ram_waddr = win_addr;
            ram_wdata = win_wdata;
         end else begin
            ram_ren   = 1'b1;
            ram_raddr = win_addr;
         end
         last_gnt_d = sel_m1;
         rd_valid_d = ~win_we;
         rd_owner_d = sel_m1;
      end

      // Streak only counts m1 wins that actually starved a waiting m0.
      if (PRIO_MODE != 0) begin
         if (!m0_req || m0_gnt)     streak_d = 4'd0;
         else if (contend && m1_gnt) streak_d = streak_q + 4'd1;
      end else begin
         streak_d = 4'd0;
      end

      m0_rvalid = rd_valid_q & ~rd_owner_q;
      m1_rvalid = rd_valid_q &  rd_owner_q;
      m0_rdata  = m0_rvalid ? ram_rdata : '0;
      m1_rdata  = m1_rvalid ? ram_rdata : '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_gnt_q <= 1'b1;
         streak_q   <= 4'd0;
         rd_valid_q <= 1'b0;
         rd_owner_q <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         streak_q   <= streak_d;
         rd_valid_q <= rd_valid_d;
         rd_owner_q <= rd_owner_d;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed bench for sram_port_arbiter
// Round-robin and fixed-priority instances share stimulus; a small SRAM model feeds both.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic        m0_we = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic [31:0] ram_rdata = '0;

   logic        rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid;
   logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_raddr, rr_waddr, rr_wdata;
   logic        rr_ren;
   logic [3:0]  rr_wen;

   logic        fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
   logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_raddr, fp_waddr, fp_wdata;
   logic        fp_ren;
   logic [3:0]  fp_wen;

   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;
   logic [31:0] mem [0:255];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.BUS_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(0), .MAX_STREAK(4)) u_rr (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
      .ram_raddr(rr_raddr), .ram_ren(rr_ren), .ram_waddr(rr_waddr), .ram_wdata(rr_wdata),
      .ram_wen(rr_wen), .ram_rdata(ram_rdata)
   );

   sram_port_arbiter #(.BUS_WIDTH(32), .DATA_WIDTH(32), .PRIO_MODE(1), .MAX_STREAK(4)) u_fp (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
      .ram_raddr(fp_raddr), .ram_ren(fp_ren), .ram_waddr(fp_waddr), .ram_wdata(fp_wdata),
      .ram_wen(fp_wen), .ram_rdata(ram_rdata)
   );

   // SRAM model attached to the round-robin instance: registered read, byte-masked write.
   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_data;
      end else begin
         for (int b = 0; b < 4; b++)
            if (rr_wen[b]) mem[rr_waddr[9:2]][8*b +: 8] <= rr_wdata[8*b +: 8];
      end
      if (rr_ren) ram_rdata <= mem[rr_raddr[9:2]];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      logic exp_m1;
      logic prev_m1;

      // Reset state and SRAM preload
      resetn = 1'b0;
      preload(8'h40, 32'hDEADBEEF);   // byte addr 0x100
      preload(8'h41, 32'h11112222);   // byte addr 0x104
      preload(8'h10, 32'hCAFEF00D);   // byte addr 0x040
      m0_req = 1'b1; m1_req = 1'b1;
      #1;
      check_eq("rst_rr_m0_gnt", rr_m0_gnt, 0);
      check_eq("rst_rr_m1_gnt", rr_m1_gnt, 0);
      check_eq("rst_rr_ren", rr_ren, 0);
      check_eq("rst_rr_wen", rr_wen, 0);
      check_eq("rst_rr_rvalid", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      check_eq("rst_fp_gnt", {fp_m0_gnt, fp_m1_gnt}, 0);
      check_eq("rst_fp_ren", fp_ren, 0);
      m0_req = 1'b0; m1_req = 1'b0;
      preload(8'h40, 32'hA5A5A5A5);
      @(negedge clk);
      resetn = 1'b1;

      // Lone m0 read of 0x100
      @(negedge clk);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
      #1;
      check_eq("solo_m0_gnt", rr_m0_gnt, 1);
      check_eq("solo_m1_gnt", rr_m1_gnt, 0);
      check_eq("solo_ren", rr_ren, 1);
      check_eq("solo_raddr", rr_raddr, 32'h100);
      check_eq("solo_wen", rr_wen, 0);
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      check_eq("solo_m0_rvalid", rr_m0_rvalid, 1);
      check_eq("solo_m0_rdata", rr_m0_rdata, 32'hA5A5A5A5);
      check_eq("solo_m1_rvalid", rr_m1_rvalid, 0);
      check_eq("solo_m1_rdata", rr_m1_rdata, 0);
      @(negedge clk);
      #1;
      check_eq("solo_rvalid_pulse", rr_m0_rvalid, 0);

      // Continuous contention: RR alternates from m0; FP m1,m1,m1,m1,m0 repeating
      do_reset();
      m0_addr = 32'h100; m1_addr = 32'h104; m0_we = 1'b0; m1_we = 1'b0;
      prev_m1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         m0_req = 1'b1; m1_req = 1'b1;
         #1;
         exp_m1 = (k % 2) == 1;
         check_eq($sformatf("rr_gnt_%0d", k), {rr_m0_gnt, rr_m1_gnt}, {~exp_m1, exp_m1});
         check_eq($sformatf("fp_gnt_%0d", k), {fp_m0_gnt, fp_m1_gnt},
                  (k == 4 || k == 9) ? 2'b10 : 2'b01);
         if (k != 0) begin
            check_eq($sformatf("rr_rvalid_%0d", k), {rr_m0_rvalid, rr_m1_rvalid},
                     {~prev_m1, prev_m1});
            check_eq($sformatf("rr_rdata_%0d", k), prev_m1 ? rr_m1_rdata : rr_m0_rdata,
                     prev_m1 ? 32'h11112222 : 32'hA5A5A5A5);
         end
         prev_m1 = exp_m1;
      end
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;
      #1;
      check_eq("rr_rvalid_last", {rr_m0_rvalid, rr_m1_rvalid}, 2'b01);
      check_eq("rr_rdata_last", rr_m1_rdata, 32'h11112222);

      // m1 partial write to 0x40, then m0 reads it back
      @(negedge clk);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
      #1;
      check_eq("wr_m1_gnt", rr_m1_gnt, 1);
      check_eq("wr_wen", rr_wen, 4'b0011);
      check_eq("wr_waddr", rr_waddr, 32'h40);
      check_eq("wr_wdata", rr_wdata, 32'h12345678);
      check_eq("wr_ren", rr_ren, 0);
      @(negedge clk);
      m1_req = 1'b0; m1_we = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
      #1;
      check_eq("rd40_m0_gnt", rr_m0_gnt, 1);
      check_eq("rd40_raddr", rr_raddr, 32'h40);
      check_eq("wr_no_rvalid", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      check_eq("rd40_rvalid", rr_m0_rvalid, 1);
      check_eq("rd40_rdata", rr_m0_rdata, 32'hCAFE5678);

      // Reset while a read return is pending
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 32'h100;
      #1;
      check_eq("mid_m0_gnt", rr_m0_gnt, 1);
      #2;
      resetn = 1'b0;
      #1;
      check_eq("mid_rst_gnt", {rr_m0_gnt, rr_m1_gnt}, 0);
      check_eq("mid_rst_ren", rr_ren, 0);
      check_eq("mid_rst_rvalid", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      @(negedge clk);
      m0_req = 1'b0;
      #1;
      check_eq("mid_rst_rvalid2", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      check_eq("post_rst_rvalid", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      @(negedge clk);
      #1;
      check_eq("post_rst_rvalid2", {rr_m0_rvalid, rr_m1_rvalid}, 0);
      m0_req = 1'b1; m1_req = 1'b1; m1_addr = 32'h104;
      #1;
      check_eq("post_rst_rr_gnt", {rr_m0_gnt, rr_m1_gnt}, 2'b10);
      check_eq("post_rst_fp_gnt", {fp_m0_gnt, fp_m1_gnt}, 2'b01);
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port on-chip SRAM macro between two requesters: m0 (instruction fetch) and m1 (data load/store).
- Sits between the requesters and the sram instance, driving its ram_* read/write strobes.
- Arbitrates per cycle, using round-robin or starvation-bounded fixed priority.
- Routes the 1-cycle-latency read data back to the requester that issued the read.

Parameters:
- BUS_WIDTH, 32, address width of requester and ram address buses.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- PRIO_MODE, 0, 0 = round-robin; 1 = m1 fixed priority with starvation bound.
- MAX_STREAK, 4, PRIO_MODE=1 only: consecutive contended m1 grants allowed before m0 is forced; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  access request; must stay high with stable fields until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  BUS_WIDTH  byte address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_wstrb, m1_wstrb  in  DATA_WIDTH/8  byte enables; ignored for reads
- m0_gnt, m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid, m1_rvalid  out  1  read data valid pulse
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data
- ram_raddr  out  BUS_WIDTH  SRAM read address
- ram_ren  out  1  SRAM read enable
- ram_waddr  out  BUS_WIDTH  SRAM write address
- ram_wdata  out  DATA_WIDTH  SRAM write data
- ram_wen  out  DATA_WIDTH/8  SRAM byte write enables
- ram_rdata  in  DATA_WIDTH  SRAM output, valid one cycle after ram_ren

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low; all flops clear on assertion.
- Handshake:
  - Transfer occurs in a cycle where mX_req && mX_gnt.
  - At most one gnt is high per cycle.
  - gnt is never high without its req.
  - A winner is granted every cycle any req is high; there are no idle bubbles.
- Issue (combinational from the winner, same cycle):
  - Read: ram_ren=1, ram_raddr=addr, ram_wen=0.
  - Write: ram_wen=wstrb, ram_waddr=addr, ram_wdata=wdata, ram_ren=0.
  - No grant: ram_ren=0, ram_wen=0; address/data outputs are 0.
- Read return:
  - Registered owner tag plus valid bit; mX_rvalid pulses exactly 1 cycle after the granted read.
  - mX_rdata = ram_rdata while rvalid. The other requester's rdata is 0 and its rvalid is 0.
  - Back-to-back reads from either or both requesters pipeline at one per cycle.
  - Writes produce no rvalid.
- Round-robin (PRIO_MODE=0):
  - 1-bit last_gnt register, updated on every grant.
  - On contention, the requester that was not last granted wins.
  - Reset value: last_gnt=m1, so m0 wins the first contention.
- Fixed priority (PRIO_MODE=1):
  - m1 wins contention. A 4-bit streak counter increments on each contended m1 grant.
  - When streak==MAX_STREAK and both request, m0 wins and streak clears.
  - streak also clears on any m0 grant and on any cycle m0_req=0.
  - Uncontended grants never increment streak.
- A lone requester is granted every cycle regardless of mode or pointer.
- Reset values: gnt 0, rvalid 0, rdata 0, ram_ren 0, ram_wen 0, last_gnt=m1, streak 0, owner tag invalid.
- Reset mid-operation: a pending read return is discarded; no rvalid appears after reset deasserts.
- Simultaneous write then read of the same address in consecutive cycles returns the new data; the SRAM provides this, and the arbiter adds no forwarding.
- Address bits are passed unmodified. The instantiating level slices the word index.

Test Plan:
- Reset then m0 read of 0x100 alone, ram_rdata=0xA5A5A5A5 next cycle → m0_gnt same cycle, ram_ren=1, ram_raddr=0x100; m0_rvalid=1 with m0_rdata=0xA5A5A5A5 one cycle later; m1_rvalid=0.
- PRIO_MODE=0, both request reads continuously for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; each rvalid lands at the correct port one cycle after its grant.
- PRIO_MODE=1, MAX_STREAK=4, both requesting for 10 cycles → grant sequence m1,m1,m1,m1,m0,m1,m1,m1,m1,m0.
- m1 write 0x12345678 to 0x40 with wstrb=0011, then m0 read 0x40 the next cycle → ram_wen=0011 with ram_waddr=0x40 on the write cycle, no rvalid for the write; m0_rvalid one cycle after its grant, showing the SRAM's updated value.
- m0 read granted, resetn asserted the following cycle before return → all outputs 0 immediately; no rvalid after deassertion; next contention grants m0 first.
